cache_ctrl: RTL and testbench

- Set-associative cache controller sitting directly upstream of the cache data array.
- Accepts single-word CPU read/write requests, holds the tag/valid arrays and per-set replacement pointers, and decides hit/miss.
- Drives the data array's set index, way select, write data and write strobe, and refills from backing memory over a valid/ready interface.
- Policy: write-through, no-write-allocate, read-allocate.

---
 rtl/cache_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cache_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Set-associative write-through / read-allocate cache controller: tag+valid lookup, refill over valid/ready.
// Read hit answers 2 cycles after accept; misses and all writes wait on the backing memory handshake.
module cache_ctrl #(
    parameter int AINDEX_WIDTH  = 6,
    parameter int CHANNEL_WIDTH = 3,
    parameter int ADDR_WIDTH    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [2**AINDEX_WIDTH-1:0]   req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [2**AINDEX_WIDTH-1:0]   rsp_rdata,
    output logic                         rsp_hit,
    output logic [AINDEX_WIDTH-1:0]      dm_addr,
    output logic [CHANNEL_WIDTH-1:0]     dm_chan,
    output logic [2**AINDEX_WIDTH-1:0]   dm_wdata,
    output logic                         dm_wr,
    input  logic [2**AINDEX_WIDTH-1:0]   dm_q,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_we,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [2**AINDEX_WIDTH-1:0]   mem_wdata,
    input  logic                         mem_rsp_valid,
    input  logic [2**AINDEX_WIDTH-1:0]   mem_rdata
);
    localparam int DW   = 2**AINDEX_WIDTH;
    localparam int TW   = ADDR_WIDTH - AINDEX_WIDTH;
    localparam int SETS = 2**AINDEX_WIDTH;
    localparam int WAYS = 2**CHANNEL_WIDTH;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_WR, MEM_RD, MEM_WAIT, FILL, RESP} state_t;
    state_t state, state_nx;

    logic                     we_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [DW-1:0]            wdata_q;
    logic [TW-1:0]            tag_mem [SETS][WAYS];
    logic [WAYS-1:0]          valid_q [SETS];
    logic [CHANNEL_WIDTH-1:0] ptr_q   [SETS];

    logic [AINDEX_WIDTH-1:0]  idx;
    logic [TW-1:0]            tag;
    logic                     hit, has_inv;
    logic [CHANNEL_WIDTH-1:0] hit_way, inv_way, victim;

    assign idx = addr_q[AINDEX_WIDTH-1:0];
    assign tag = addr_q[ADDR_WIDTH-1:AINDEX_WIDTH];

    // Descending scans so the lowest-numbered matching / invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_mem[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = CHANNEL_WIDTH'(w);
            end
            if (!valid_q[idx][w]) begin
                has_inv = 1'b1;
                inv_way = CHANNEL_WIDTH'(w);
            end
        end
        victim = has_inv ? inv_way : ptr_q[idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        dm_addr       = '0;
        dm_chan       = '0;
        dm_wdata      = '0;
        dm_wr         = 1'b0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = LOOKUP;
            end
            LOOKUP: begin
                dm_addr = idx;
                dm_chan = hit_way;
                if (we_q) begin
                    dm_wr    = hit;
                    dm_wdata = hit ? wdata_q : '0;
                    state_nx = MEM_WR;
                end else begin
                    state_nx = hit ? RESP : MEM_RD;
                end
            end
            MEM_WR: begin
                mem_req_valid = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = addr_q;
                mem_wdata     = wdata_q;
                if (mem_req_ready) state_nx = RESP;
            end
            MEM_RD: begin
                mem_req_valid = 1'b1;
                mem_addr      = addr_q;
                if (mem_req_ready) state_nx = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_rsp_valid) state_nx = FILL;
            end
            FILL: begin
                dm_addr  = idx;
                dm_chan  = victim;
                dm_wr    = 1'b1;
                dm_wdata = rsp_rdata;
                state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // rsp_rdata doubles as the refill buffer between MEM_WAIT and FILL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_hit   <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == LOOKUP) begin
                rsp_hit <= hit;
                if (!we_q && hit) rsp_rdata <= dm_q;
            end
            if (state == MEM_WR && mem_req_ready) rsp_rdata <= '0;
            if (state == MEM_WAIT && mem_rsp_valid) rsp_rdata <= mem_rdata;
            if (state == FILL) begin
                valid_q[idx][victim] <= 1'b1;
                if (!has_inv) ptr_q[idx] <= ptr_q[idx] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL) tag_mem[idx][victim] <= tag;
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed vector table, stall/reset sequences, then random traffic vs a cache model.
module tb_cache_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_hit;
    logic [63:0] rsp_rdata;
    logic [5:0]  dm_addr;
    logic [2:0]  dm_chan;
    logic [63:0] dm_wdata, dm_q;
    logic        dm_wr;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit),
        .dm_addr(dm_addr), .dm_chan(dm_chan), .dm_wdata(dm_wdata), .dm_wr(dm_wr), .dm_q(dm_q),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    // Environment: the data array and the backing memory device.
    logic [63:0] darr [64][8];
    logic [63:0] bmem [65536];
    assign dm_q = darr[dm_addr][dm_chan];
    always @(posedge clk) if (dm_wr) darr[dm_addr][dm_chan] <= dm_wdata;

    // Reference model: architectural memory contents plus per-set tag/valid/round-robin state.
    logic [63:0] rmem [65536];
    bit          m_valid [64][8];
    int          m_tag   [64][8];
    int          m_ptr   [64];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          timeout, hit, dmwr_b2b, unstable, idle_after, mem_we;
        logic [63:0] rdata, dm_wdata, mem_wdata;
        logic [15:0] mem_addr;
        int          lat, nmem, ndmwr, dm_chan;
    } res_t;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [63:0] wd;
        bit          hit;
        logic [63:0] rd;
        int          nmem, ndw, chan, lat;
    } vec_t;

    function automatic vec_t mk(bit we, logic [15:0] a, logic [63:0] wd, bit h, logic [63:0] rd,
                                int nm, int ndw, int ch, int lat);
        vec_t v;
        v.we = we; v.addr = a; v.wd = wd; v.hit = h; v.rd = rd;
        v.nmem = nm; v.ndw = ndw; v.chan = ch; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < 8; w++) m_valid[s][w] = 0;
        end
    endtask

    // Returns hit and the way touched (hit way, or refill victim on a read miss).
    task automatic model_access(input bit we, input logic [15:0] addr, input logic [63:0] wd,
                                output bit hit, output int way);
        int s, t;
        s = int'(addr) % 64;
        t = int'(addr) / 64;
        hit = 0;
        way = 0;
        for (int w = 0; w < 8; w++)
            if (!hit && m_valid[s][w] && m_tag[s][w] == t) begin hit = 1; way = w; end
        if (we) rmem[addr] = wd;
        else if (!hit) begin
            way = -1;
            for (int w = 0; w < 8; w++) if (way < 0 && !m_valid[s][w]) way = w;
            if (way < 0) begin way = m_ptr[s]; m_ptr[s] = (m_ptr[s] + 1) % 8; end
            m_valid[s][way] = 1;
            m_tag[s][way] = t;
        end
    endtask

    task automatic do_req(input bit we, input logic [15:0] addr, input logic [63:0] wd,
                          input int mstall, input int rstall, input int mwait, output res_t r);
        int  cyc, ms, rs, mw;
        bit  done, prev_wr;
        r = '{default: 0};
        @(negedge clk);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd;
        cyc = 0;
        while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
        if (!req_ready) begin r.timeout = 1; req_valid = 0; return; end
        @(posedge clk); #1;
        req_valid = 0;
        cyc = 0; ms = 0; rs = 0; mw = -1; done = 0; prev_wr = 0;
        while (!done && cyc < 200) begin
            @(negedge clk); cyc++;
            mem_req_ready = 0; rsp_ready = 0; mem_rsp_valid = 0;
            if (dm_wr) begin
                if (prev_wr) r.dmwr_b2b = 1;
                r.ndmwr++; r.dm_chan = int'(dm_chan); r.dm_wdata = dm_wdata;
            end
            prev_wr = dm_wr;
            if (mem_req_valid) begin
                if (ms == 0) begin
                    r.mem_we = mem_we; r.mem_addr = mem_addr; r.mem_wdata = mem_wdata;
                end else if (mem_we !== r.mem_we || mem_addr !== r.mem_addr || mem_wdata !== r.mem_wdata)
                    r.unstable = 1;
                if (ms >= mstall) begin
                    mem_req_ready = 1; r.nmem++; ms = 0;
                    if (mem_we) bmem[mem_addr] = mem_wdata;
                    else mw = mwait;
                end else begin
                    ms++;
                    if (ms == 2) begin mem_rsp_valid = 1; mem_rdata = {$urandom, $urandom}; end
                end
            end else if (mw == 0) begin
                mem_rsp_valid = 1; mem_rdata = bmem[r.mem_addr]; mw = -1;
            end else if (mw > 0) mw--;
            if (rsp_valid) begin
                if (rs == 0) begin r.lat = cyc; r.rdata = rsp_rdata; r.hit = rsp_hit; end
                else if (rsp_rdata !== r.rdata || rsp_hit !== r.hit) r.unstable = 1;
                if (rs >= rstall) begin rsp_ready = 1; done = 1; end
                rs++;
            end
        end
        @(posedge clk); #1;
        rsp_ready = 0; mem_rsp_valid = 0; mem_req_ready = 0;
        r.idle_after = req_ready && !rsp_valid;
        if (!done) r.timeout = 1;
    endtask

    task automatic check_res(input string nm, input bit we, input logic [15:0] addr, input logic [63:0] wd,
                             input res_t r, input bit eh, input logic [63:0] erd, input int enm,
                             input int endw, input int ech, input logic [63:0] edw, input int elat);
        chk({nm, ".timeout"}, r.timeout, 0);
        chk({nm, ".hit"}, r.hit, eh);
        chk({nm, ".rdata"}, r.rdata, erd);
        chk({nm, ".nmem"}, r.nmem, enm);
        chk({nm, ".ndmwr"}, r.ndmwr, endw);
        chk({nm, ".dmwr_b2b"}, r.dmwr_b2b, 0);
        chk({nm, ".stable"}, r.unstable, 0);
        chk({nm, ".idle_after"}, r.idle_after, 1);
        if (endw > 0) begin
            chk({nm, ".dm_chan"}, r.dm_chan, ech);
            chk({nm, ".dm_wdata"}, r.dm_wdata, edw);
        end
        if (enm > 0) begin
            chk({nm, ".mem_we"}, r.mem_we, we);
            chk({nm, ".mem_addr"}, r.mem_addr, addr);
            if (we) chk({nm, ".mem_wdata"}, r.mem_wdata, wd);
        end
        if (elat > 0) chk({nm, ".latency"}, r.lat, elat);
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, ".req_ready"}, req_ready, 1);
        chk({nm, ".rsp_valid"}, rsp_valid, 0);
        chk({nm, ".rsp_hit"}, rsp_hit, 0);
        chk({nm, ".rsp_rdata"}, rsp_rdata, 0);
        chk({nm, ".dm_wr"}, dm_wr, 0);
        chk({nm, ".dm_addr_chan"}, {dm_addr, dm_chan}, 0);
        chk({nm, ".mem_req_valid"}, mem_req_valid, 0);
        chk({nm, ".mem_we"}, mem_we, 0);
        chk({nm, ".mem_addr"}, mem_addr, 0);
    endtask

    vec_t tbl[18];
    res_t r;
    bit   mh;
    int   mway;

    initial begin
        tbl[0]  = mk(0, 16'h0041, 64'h0,    0, 64'hDEAD, 1, 1, 0, 0);
        tbl[1]  = mk(0, 16'h0041, 64'h0,    1, 64'hDEAD, 0, 0, 0, 2);
        tbl[2]  = mk(1, 16'h0041, 64'hBEEF, 1, 64'h0,    1, 1, 0, 0);
        tbl[3]  = mk(0, 16'h0041, 64'h0,    1, 64'hBEEF, 0, 0, 0, 2);
        tbl[4]  = mk(1, 16'h0082, 64'h1234, 0, 64'h0,    1, 0, 0, 0);
        tbl[5]  = mk(0, 16'h0082, 64'h0,    0, 64'h1234, 1, 1, 0, 0);
        tbl[6]  = mk(0, 16'h0081, 64'h0,    0, 64'hC0DE_0000_0000_0081, 1, 1, 1, 0);
        tbl[7]  = mk(0, 16'h00C1, 64'h0,    0, 64'hC0DE_0000_0000_00C1, 1, 1, 2, 0);
        tbl[8]  = mk(0, 16'h0101, 64'h0,    0, 64'hC0DE_0000_0000_0101, 1, 1, 3, 0);
        tbl[9]  = mk(0, 16'h0141, 64'h0,    0, 64'hC0DE_0000_0000_0141, 1, 1, 4, 0);
        tbl[10] = mk(0, 16'h0181, 64'h0,    0, 64'hC0DE_0000_0000_0181, 1, 1, 5, 0);
        tbl[11] = mk(0, 16'h01C1, 64'h0,    0, 64'hC0DE_0000_0000_01C1, 1, 1, 6, 0);
        tbl[12] = mk(0, 16'h0201, 64'h0,    0, 64'hC0DE_0000_0000_0201, 1, 1, 7, 0);
        tbl[13] = mk(0, 16'h0241, 64'h0,    0, 64'hC0DE_0000_0000_0241, 1, 1, 0, 0);
        tbl[14] = mk(0, 16'h0281, 64'h0,    0, 64'hC0DE_0000_0000_0281, 1, 1, 1, 0);
        tbl[15] = mk(0, 16'h0041, 64'h0,    0, 64'hBEEF, 1, 1, 2, 0);
        tbl[16] = mk(0, 16'h0081, 64'h0,    0, 64'hC0DE_0000_0000_0081, 1, 1, 3, 0);
        tbl[17] = mk(0, 16'h0201, 64'h0,    1, 64'hC0DE_0000_0000_0201, 0, 0, 0, 2);

        for (int a = 0; a < 65536; a++) begin
            bmem[a] = {16'hC0DE, 32'h0, 16'(a)};
            rmem[a] = bmem[a];
        end
        bmem[16'h0041] = 64'hDEAD;
        rmem[16'h0041] = 64'hDEAD;
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 8; w++) darr[s][w] = 64'h0;
        model_reset();

        reset = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
        rsp_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 0;

        for (int i = 0; i < 18; i++) begin
            model_access(tbl[i].we, tbl[i].addr, tbl[i].wd, mh, mway);
            do_req(tbl[i].we, tbl[i].addr, tbl[i].wd, 0, 0, 1, r);
            check_res($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wd, r, tbl[i].hit,
                      tbl[i].rd, tbl[i].nmem, tbl[i].ndw, tbl[i].chan,
                      tbl[i].we ? tbl[i].wd : tbl[i].rd, tbl[i].lat);
        end

        // Long memory and CPU stalls on a write and on a read miss.
        model_access(1, 16'h00C5, 64'h5555_AAAA, mh, mway);
        do_req(1, 16'h00C5, 64'h5555_AAAA, 5, 3, 0, r);
        check_res("stall_wr", 1, 16'h00C5, 64'h5555_AAAA, r, 0, 64'h0, 1, 0, 0, 64'h0, 0);
        model_access(0, 16'h00C5, 64'h0, mh, mway);
        do_req(0, 16'h00C5, 64'h0, 5, 3, 4, r);
        check_res("stall_rd", 0, 16'h00C5, 64'h0, r, 0, 64'h5555_AAAA, 1, 1, 0, 64'h5555_AAAA, 0);

        // Reset while waiting for refill data: transaction is dropped, all lines invalidated.
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = 16'h0301;
        @(posedge clk); #1;
        req_valid = 0;
        for (int i = 0; i < 20 && !mem_req_valid; i++) @(negedge clk);
        chk("rst_mid.mem_req_seen", mem_req_valid, 1);
        mem_req_ready = 1;
        @(posedge clk); #1;
        mem_req_ready = 0;
        repeat (2) @(negedge clk);
        reset = 1; #1;
        check_idle_outputs("rst_mid");
        @(negedge clk);
        reset = 0;
        mem_rsp_valid = 1; mem_rdata = 64'hBAD0_BAD0;
        @(negedge clk);
        mem_rsp_valid = 0;
        begin
            int seen = 0;
            repeat (5) begin @(negedge clk); if (rsp_valid) seen++; end
            chk("rst_mid.no_rsp", seen, 0);
        end
        model_reset();
        model_access(0, 16'h0041, 64'h0, mh, mway);
        do_req(0, 16'h0041, 64'h0, 0, 0, 0, r);
        check_res("post_rst", 0, 16'h0041, 64'h0, r, 0, 64'hBEEF, 1, 1, 0, 64'hBEEF, 0);

        // Random traffic over a few sets with enough tags to force evictions.
        for (int n = 0; n < 250; n++) begin
            bit          we;
            logic [15:0] a;
            logic [63:0] wd, erd;
            we = ($urandom_range(0, 9) < 3);
            a  = {6'(0), 4'($urandom_range(0, 11)), 6'($urandom_range(0, 3))};
            wd = {$urandom, $urandom};
            erd = we ? 64'h0 : rmem[a];
            model_access(we, a, wd, mh, mway);
            if (!we) erd = rmem[a];
            do_req(we, a, wd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r);
            check_res($sformatf("rnd%0d", n), we, a, wd, r, mh, erd,
                      (we || !mh) ? 1 : 0, ((we && mh) || (!we && !mh)) ? 1 : 0, mway,
                      we ? wd : rmem[a], (!we && mh) ? 2 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
